// File: rtl/bcd2bin_set.sv
// Loads a BCD hh:mm:ss time, validates it, converts one field per cycle and commits atomically.
// Optional BCD2BIN_HR12_EN restricts hours to 1..12 instead of 0..23.
module bcd2bin_set #(
  parameter int unsigned SEC_MAX = 59,
  parameter int unsigned MIN_MAX = 59
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] Sec_Least,
  input  logic [3:0] Sec_Most,
  input  logic [3:0] Min_Least,
  input  logic [3:0] Min_Most,
  input  logic [3:0] Hr_Least,
  input  logic [3:0] Hr_Most,
  output logic [7:0] Sec_bin,
  output logic [7:0] Min_bin,
  output logic [7:0] Hr_bin,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StConvSec,
    StConvMin,
    StConvHr,
    StCommit
  } state_e;

  localparam logic [7:0] SecMax = SEC_MAX[7:0];
  localparam logic [7:0] MinMax = MIN_MAX[7:0];

  state_e state_q, state_d;

  logic [3:0] sec_l_q, sec_m_q, min_l_q, min_m_q, hr_l_q, hr_m_q;
  logic [7:0] sec_stg_q, min_stg_q, hr_stg_q;
  logic [7:0] sec_v, min_v, hr_v;
  logic       digits_ok, hr_ok, check_ok;

  // 10*most + least built from shifts so no multiplier is inferred.
  function automatic logic [7:0] bcd_val(input logic [3:0] most, input logic [3:0] least);
    return ({4'b0, most} << 3) + ({4'b0, most} << 1) + {4'b0, least};
  endfunction

  always_comb begin
    sec_v     = bcd_val(sec_m_q, sec_l_q);
    min_v     = bcd_val(min_m_q, min_l_q);
    hr_v      = bcd_val(hr_m_q, hr_l_q);
    digits_ok = (sec_l_q <= 4'd9) && (sec_m_q <= 4'd9) && (min_l_q <= 4'd9) &&
                (min_m_q <= 4'd9) && (hr_l_q <= 4'd9) && (hr_m_q <= 4'd9);
`ifdef BCD2BIN_HR12_EN
    hr_ok     = (hr_v >= 8'd1) && (hr_v <= 8'd12);
`else
    hr_ok     = (hr_v <= 8'd23);
`endif
    check_ok  = digits_ok && hr_ok && (sec_v <= SecMax) && (min_v <= MinMax);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start) state_d = StCheck;
      StCheck:   state_d = check_ok ? StConvSec : StIdle;
      StConvSec: state_d = StConvMin;
      StConvMin: state_d = StConvHr;
      StConvHr:  state_d = StCommit;
      StCommit:  state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      sec_l_q   <= '0;
      sec_m_q   <= '0;
      min_l_q   <= '0;
      min_m_q   <= '0;
      hr_l_q    <= '0;
      hr_m_q    <= '0;
      sec_stg_q <= '0;
      min_stg_q <= '0;
      hr_stg_q  <= '0;
      Sec_bin   <= '0;
      Min_bin   <= '0;
      Hr_bin    <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (state_q == StIdle && start) begin
        sec_l_q <= Sec_Least;
        sec_m_q <= Sec_Most;
        min_l_q <= Min_Least;
        min_m_q <= Min_Most;
        hr_l_q  <= Hr_Least;
        hr_m_q  <= Hr_Most;
      end
      if (state_q == StConvSec) sec_stg_q <= sec_v;
      if (state_q == StConvMin) min_stg_q <= min_v;
      if (state_q == StConvHr)  hr_stg_q  <= hr_v;
      // All three fields land on one edge so no partial time is ever visible.
      if (state_q == StCommit) begin
        Sec_bin <= sec_stg_q;
        Min_bin <= min_stg_q;
        Hr_bin  <= hr_stg_q;
      end
      done <= (state_q == StCommit);
      err  <= (state_q == StCheck) && !check_ok;
    end
  end

  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_bcd2bin_set.sv
// Directed bench for bcd2bin_set: a cycle-level reference model checked every cycle plus
// hand-computed literal expectations; hour-range cases follow BCD2BIN_HR12_EN.
module tb_bcd2bin_set;

  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
`ifdef BCD2BIN_HR12_EN
  localparam int HR_T = 12;
  localparam int RST_HR = 1;
`else
  localparam int HR_T = 23;
  localparam int RST_HR = 0;
`endif

  logic       CLK = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] sl, sm, ml, mm, hl, hm;
  logic [7:0] Sec_bin, Min_bin, Hr_bin;
  logic       busy, done, err;

  int n_chk = 0;
  int n_fail = 0;
  int n_done = 0;
  bit checking = 1'b0;

  bcd2bin_set #(.SEC_MAX(SEC_MAX), .MIN_MAX(MIN_MAX)) dut (
    .CLK(CLK), .rst(rst), .start(start),
    .Sec_Least(sl), .Sec_Most(sm), .Min_Least(ml), .Min_Most(mm),
    .Hr_Least(hl), .Hr_Most(hm),
    .Sec_bin(Sec_bin), .Min_bin(Min_bin), .Hr_bin(Hr_bin),
    .busy(busy), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a request resolves err after 1 edge or commits after 5.
  int m_cnt, m_sec, m_min, m_hr, p_sec, p_min, p_hr;
  bit m_bad, m_done, m_err;
  always @(posedge CLK or posedge rst) begin
    if (rst) begin
      m_cnt = 0; m_sec = 0; m_min = 0; m_hr = 0; m_done = 0; m_err = 0;
    end else begin
      m_done = 0;
      m_err  = 0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          if (m_bad) m_err = 1;
          else begin
            m_sec = p_sec; m_min = p_min; m_hr = p_hr; m_done = 1;
          end
        end
      end else if (start) begin
        p_sec = 10 * int'(sm) + int'(sl);
        p_min = 10 * int'(mm) + int'(ml);
        p_hr  = 10 * int'(hm) + int'(hl);
        m_bad = (sl > 9) || (sm > 9) || (ml > 9) || (mm > 9) || (hl > 9) || (hm > 9) ||
                (p_sec > SEC_MAX) || (p_min > MIN_MAX);
`ifdef BCD2BIN_HR12_EN
        if (p_hr < 1 || p_hr > 12) m_bad = 1;
`else
        if (p_hr > 23) m_bad = 1;
`endif
        m_cnt = m_bad ? 1 : 5;
      end
    end
  end

  always @(negedge CLK) begin
    if (checking && !rst) begin
      chk("sec_bin", Sec_bin, m_sec);
      chk("min_bin", Min_bin, m_min);
      chk("hr_bin", Hr_bin, m_hr);
      chk("busy", busy, m_cnt != 0);
      chk("done", done, m_done);
      chk("err", err, m_err);
      if (done) n_done++;
    end
  end

  task automatic run_req(input int h, input int m, input int s, input logic [3:0] s_lo_over,
                         input bit use_over, input bit scramble, input bit restart,
                         output int lat, output int busy_n);
    hm = 4'(h / 10); hl = 4'(h % 10);
    mm = 4'(m / 10); ml = 4'(m % 10);
    sm = 4'(s / 10); sl = use_over ? s_lo_over : 4'(s % 10);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    if (scramble) begin
      hm = 4'd1; hl = 4'd1; mm = 4'd2; ml = 4'd2; sm = 4'd3; sl = 4'd3;
    end
    lat = -1;
    busy_n = 0;
    for (int j = 0; j < 20; j++) begin
      if (restart && j == 1) begin
        hm = 4'd1; hl = 4'd1; mm = 4'd1; ml = 4'd1; sm = 4'd1; sl = 4'd1;
        start = 1'b1;
      end
      if (restart && j == 2) start = 1'b0;
      if (done || err) begin
        lat = j;
        break;
      end
      if (busy) busy_n++;
      @(negedge CLK);
    end
  endtask

  int lat, bn, d0;

  initial begin
    rst = 1'b1; start = 1'b0;
    {sl, sm, ml, mm, hl, hm} = '0;
    repeat (3) @(negedge CLK);
    chk("rst_sec", Sec_bin, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done_err", {done, err}, 0);
    #2 rst = 1'b0;
    @(negedge CLK);
    checking = 1'b1;

    // Max legal time: done after edge k+5, busy for 5 cycles.
    run_req(HR_T, 59, 59, 4'd0, 0, 0, 0, lat, bn);
    chk("max_lat", lat, 5);
    chk("max_busy_cycles", bn, 5);
    chk("max_hr", Hr_bin, HR_T);
    chk("max_min", Min_bin, 59);
    chk("max_sec", Sec_bin, 59);

    // Back-to-back request on the IDLE cycle right after done; Sec_Least = A is rejected.
    run_req(1, 2, 3, 4'hA, 1, 0, 0, lat, bn);
    chk("bad_digit_lat", lat, 1);
    chk("bad_digit_err", err, 1);
    chk("bad_digit_keep_sec", Sec_bin, 59);
    chk("bad_digit_keep_hr", Hr_bin, HR_T);

    run_req(10, 60, 0, 4'd0, 0, 0, 0, lat, bn);
    chk("min60_lat", lat, 1);
    run_req(10, 0, 60, 4'd0, 0, 0, 0, lat, bn);
    chk("sec60_lat", lat, 1);
`ifdef BCD2BIN_HR12_EN
    run_req(13, 0, 0, 4'd0, 0, 0, 0, lat, bn);
    chk("hr13_err_lat", lat, 1);
    run_req(0, 30, 0, 4'd0, 0, 0, 0, lat, bn);
    chk("hr00_err_lat", lat, 1);
`else
    run_req(24, 0, 0, 4'd0, 0, 0, 0, lat, bn);
    chk("hr24_err_lat", lat, 1);
    run_req(0, 30, 0, 4'd0, 0, 0, 0, lat, bn);
    chk("hr00_lat", lat, 5);
    chk("hr00_min", Min_bin, 30);
`endif
    run_req(12, 0, 0, 4'd0, 0, 0, 0, lat, bn);
    chk("hr12_lat", lat, 5);
    chk("hr12_val", Hr_bin, 12);

    // Second start at k+2 must be ignored.
    @(negedge CLK);
    d0 = n_done;
    run_req(1, 2, 3, 4'd0, 0, 0, 1, lat, bn);
    chk("ovl_lat", lat, 5);
    chk("ovl_hr", Hr_bin, 1);
    chk("ovl_min", Min_bin, 2);
    chk("ovl_sec", Sec_bin, 3);
    repeat (8) @(negedge CLK);
    chk("ovl_done_count", n_done - d0, 1);

    // Digits change after the start edge; captured values win.
    run_req(4, 5, 6, 4'd0, 0, 1, 0, lat, bn);
    chk("scr_lat", lat, 5);
    chk("scr_hr", Hr_bin, 4);
    chk("scr_min", Min_bin, 5);
    chk("scr_sec", Sec_bin, 6);

    // Reset while in CONV_MIN aborts with no done pulse.
    @(negedge CLK);
    hm = 4'd0; hl = 4'd1; mm = 4'd0; ml = 4'd2; sm = 4'd0; sl = 4'd3;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (2) @(negedge CLK);
    d0 = n_done;
    #2 rst = 1'b1;
    #1;
    chk("arst_sec", Sec_bin, 0);
    chk("arst_min", Min_bin, 0);
    chk("arst_hr", Hr_bin, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done_err", {done, err}, 0);
    @(negedge CLK);
    #2 rst = 1'b0;
    repeat (6) @(negedge CLK);
    chk("arst_no_done", n_done - d0, 0);
    run_req(RST_HR, 0, 7, 4'd0, 0, 0, 0, lat, bn);
    chk("post_rst_lat", lat, 5);
    chk("post_rst_sec", Sec_bin, 7);
    repeat (3) @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd2bin_set.md
BCD2BIN_SET -- requirements
Module: bcd2bin_set

Interface
REQ-001 SHALL have parameter SEC_MAX, default 59, the largest legal seconds value.
REQ-002 SHALL have parameter MIN_MAX, default 59, the largest legal minutes value.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: one-cycle request to load a time.
REQ-006 SHALL have ports Sec_Least, Sec_Most, Min_Least, Min_Most, Hr_Least, Hr_Most, each input, 4 bits: the BCD digits of the time to load.
REQ-007 SHALL have ports Sec_bin, Min_bin, Hr_bin, each output, 8 bits: the registered binary time.
REQ-008 SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when new outputs are committed.
REQ-010 SHALL have port err, output, 1 bit: one-cycle pulse when a request is rejected.

Function
REQ-011 SHALL implement the FSM states IDLE, CHECK, CONV_SEC, CONV_MIN, CONV_HR and COMMIT.
REQ-012 SHALL, in IDLE, on the edge where start=1, capture all six digits into internal registers and go to CHECK.
REQ-013 SHALL have CHECK flag an error if any captured digit is greater than 9.
REQ-014 SHALL have CHECK flag an error if 10*Most+Least exceeds the limit for its field:
- seconds: SEC_MAX
- minutes: MIN_MAX
- hours: 23, or per REQ-026.
REQ-015 SHALL, on an error, pulse err for exactly one cycle, return to IDLE, and leave Sec_bin, Min_bin and Hr_bin unchanged.
REQ-016 SHALL, when CHECK passes, step CONV_SEC -> CONV_MIN -> CONV_HR, computing one field per cycle as (Most<<3)+(Most<<1)+Least into an 8-bit staging register.
- No multiplier SHALL be used.
REQ-017 SHALL, in COMMIT, load Sec_bin, Min_bin and Hr_bin together on the same edge, pulse done for one cycle, and return to IDLE.
- Outputs SHALL never show a partially updated time.
REQ-018 SHALL have fixed latency: start sampled on edge k gives either err high after edge k+1, or done high and new outputs after edge k+5.
REQ-019 SHALL hold busy high in every state other than IDLE.
- busy SHALL fall together with the done or err pulse.
REQ-020 SHALL ignore start while busy=1; no queuing.
REQ-021 SHALL convert from the captured digits only; input changes after the start edge SHALL have no effect.
REQ-022 SHALL never assert done and err in the same cycle.
REQ-023 SHALL accept a start on the first IDLE cycle after done or err, giving back-to-back requests every 6 cycles.

Reset
REQ-024 SHALL, while rst=1, asynchronously force:
- state to IDLE
- Sec_bin, Min_bin, Hr_bin to 0
- busy, done, err to 0
- digit and staging registers to 0.
REQ-025 SHALL, on reset during any non-IDLE state, abort the conversion with no done or err pulse; the first start after release SHALL be processed normally.

Configuration
REQ-026 SHALL support macro BCD2BIN_HR12_EN; when defined, the legal hour range SHALL be 1..12, so hour 00 or greater than 12 raises err. When undefined, the legal hour range SHALL be 0..23.

Verification
REQ-027 SHALL cover: digits 2,3:5,9:5,9 (hr:min:sec) with start -> after edge k+5, Hr_bin=23, Min_bin=59, Sec_bin=59, done=1 for one cycle, busy high for 5 cycles.
REQ-028 SHALL cover: Sec_Least=4'hA with other digits valid -> err pulse after edge k+1, outputs keep prior values, done stays 0.
REQ-029 SHALL cover: time 24:00:00, macro undefined -> err; time 13:00:00 and 00:30:00 with BCD2BIN_HR12_EN -> err; time 12:00:00 with macro -> Hr_bin=12.
REQ-030 SHALL cover: start at k with 01:02:03, a second start at k+2 with 11:11:11 -> only 01:02:03 committed (Hr_bin=1, Min_bin=2, Sec_bin=3), exactly one done pulse.
REQ-031 SHALL cover: rst pulsed in CONV_MIN -> all outputs 0 immediately, no done pulse; next start with 00:00:07 -> Sec_bin=7.
REQ-032 SHALL cover: digits changed on the cycle after start -> committed values equal the digits present at the start edge.
